// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
// Bundles the host-side byte FIFO signals and the transmitter handshake
// of uart_tx_feeder into one interface.
//   wr_en, wr_dat  : byte write strobe and data into the FIFO
//   full, empty    : FIFO occupancy flags
//   level          : FIFO occupancy count, 0..2^DEPTH_LOG2
//   ovf, tx_err    : sticky overflow and handshake-timeout flags
//   err_clr        : clears both sticky flags
//   tx_ing         : busy flag from the UART transmitter
//   tx_en, tx_dat  : one-cycle launch pulse and byte to the transmitter
// Modports: master = host/transmitter side, slave = the feeder itself.
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_dat;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  ovf;
  logic                  tx_err;
  logic                  err_clr;
  logic                  tx_ing;
  logic                  tx_en;
  logic [7:0]            tx_dat;

  modport master (
    output wr_en, wr_dat, err_clr, tx_ing,
    input  full, empty, level, ovf, tx_err, tx_en, tx_dat
  );

  modport slave (
    input  wr_en, wr_dat, err_clr, tx_ing,
    output full, empty, level, ovf, tx_err, tx_en, tx_dat
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO plus launch sequencer placed directly upstream of the UART
// transmitter. Bytes are popped one at a time into tx_dat, launched with
// a single-cycle tx_en, and the transmitter's tx_ing busy flag is then
// tracked until the frame completes. A frame whose tx_ing never rises
// within ACK_TIMEOUT cycles is dropped and flagged on tx_err.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : uart_tx_feeder_if.slave (FIFO write side, status, tx handshake)
// Optional feature: define UART_TX_GAP_EN to insert GAP_CYCLES idle
// clocks after every completed frame.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4,
  parameter int GAP_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_feeder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  // Both counters compare against (value - 1), so zero would never match.
  if (ACK_TIMEOUT < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("uart_tx_feeder: ACK_TIMEOUT and GAP_CYCLES must be at least 1");
  end

`ifdef UART_TX_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [ACK_W-1:0]      ack_cnt;
`ifdef UART_TX_GAP_EN
  logic [GAP_W-1:0]      gap_cnt;
`endif
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  pop;
  logic                  timeout;
  logic                  ovf;
  logic                  tx_err;
  logic                  tx_en;
  logic [7:0]            tx_dat;

  // full is derived from the registered level, so a pop in the same cycle
  // cannot rescue a write that arrives while full.
  assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_ok = bus.wr_en && !full;

  // Next-state logic; pop only ever fires from IDLE with data present and
  // the transmitter idle, so the FIFO is never read while empty.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !bus.tx_ing) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_ing) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_ing) begin
`ifdef UART_TX_GAP_EN
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus the per-state counters. tx_en is registered from
  // the next state so it is high for exactly the START cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      ack_cnt <= '0;
`ifdef UART_TX_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      tx_en <= (state_next == START);
      if (state == START) begin
        ack_cnt <= '0;
      end else if (state == WAIT_BUSY && !bus.tx_ing) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
`ifdef UART_TX_GAP_EN
      if (state == WAIT_DONE) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
`endif
    end
  end

  // Storage needs no reset: reset empties the queue via the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.wr_dat;
    end
  end

  // Pointers, occupancy and the launched byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      tx_dat <= 8'h00;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_dat <= mem[rd_ptr];
      end
      unique case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a set event outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf    <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        ovf <= 1'b1;
      end else if (bus.err_clr) begin
        ovf <= 1'b0;
      end
      if (timeout) begin
        tx_err <= 1'b1;
      end else if (bus.err_clr) begin
        tx_err <= 1'b0;
      end
    end
  end

  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.level  = level;
  assign bus.ovf    = ovf;
  assign bus.tx_err = tx_err;
  assign bus.tx_en  = tx_en;
  assign bus.tx_dat = tx_dat;
endmodule
